floating_point_to_integer: RTL and testbench
============================================

Name: floating_point_to_integer

Overview:
- Iterative, multi-cycle converter from IEEE-754 single precision to a signed two's-complement integer.
- It is the inverse of the float add/sub datapath: that datapath packs {sign, exponent, mantissa}; this block unpacks the fields and denormalizes the significand into an integer.
- Rounding is truncation toward zero. Out-of-range inputs saturate.
- Sits after the FP arithmetic units and uses a start/ready/valid handshake.

Parameters:
- DATA_WIDTH, 32, floating input width
- MENT_WIDTH, 23, mantissa field width
- EXPO_WIDTH, 8, exponent field width
- INT_WIDTH, 32, integer output width
- EXP_BIAS, 127, exponent bias

Ports:
- clk_in  input  1  clock; every register updates on its rising edge
- rst_in  input  1  reset, synchronous, active-high
- start_in  input  1  request; accepted only when ready_out=1
- floating_in  input  DATA_WIDTH  operand; sampled on the accept edge
- ready_out  output  1  high only in IDLE
- valid_out  output  1  one-cycle result pulse
- integer_out  output  INT_WIDTH  result; holds until the next result
- overflow_out  output  1  input was out of range, or was ±Inf
- invalid_out  output  1  input was NaN
- inexact_out  output  1  nonzero fraction bits were discarded

Behaviour:
- Reset values: state=IDLE, ready_out=1, valid_out=0, integer_out=0, all flags=0.
- Reset applied mid-operation aborts the conversion. The block is in IDLE with reset values in the cycle after the reset edge.
- FSM states and transitions:
  - IDLE: on start_in=1, latch floating_in → CLASSIFY.
  - CLASSIFY: decode the fields; e = exp − EXP_BIAS; significand S = {1, mant}, width 24, zero-extended to INT_WIDTH.
    - exp=255, mant≠0 → NaN case.
    - exp=255, mant=0 → Inf case.
    - exp=0 (zero or denormal), or e<0 → zero case.
    - e≥31 → overflow case. Exception: the input 0xCF000000 (−2^31) is exact.
    - Normal case, 0≤e≤30: shift count n = |e−23|, direction = left if e≥23, else right.
    - Next state is SHIFT if n>0, else SIGN.
  - SHIFT: shift S one bit per cycle in the chosen direction and decrement n. On a right shift, OR the bit shifted out into a sticky register. When n reaches 0 → SIGN.
  - SIGN: register the results into the output registers → DONE.
    - Normal case: integer_out = sign ? −S : S; inexact_out = sticky.
    - NaN: integer_out=0, invalid_out=1.
    - +Inf, or positive overflow: 0x7FFFFFFF, overflow_out=1.
    - −Inf, or negative overflow: 0x80000000, overflow_out=1.
    - −2^31 exact: 0x80000000, no flags.
    - Zero case: 0; inexact_out=1 if the input was nonzero in exp or mant, excluding the sign bit.
  - DONE: valid_out=1 for exactly this cycle → IDLE.
- Latency: valid_out is high in the cycle after the edge n+2 edges after the accept edge. Special cases use n=0, so latency is 2. The maximum is 25 (e=0, n=23).
- start_in while ready_out=0 is ignored, not queued.
- A new start is accepted back-to-back: IDLE is reached in the cycle after DONE.
- Flags and integer_out update only on the SIGN→DONE edge and are stable until the next one.
- ±0 gives 0 with no flags.

Test Plan:
- 0x40490FDB (π): e=1, n=22 right → integer_out=0x00000003, inexact_out=1, valid_out 24 cycles after accept.
- 0xC2F60000 (−123.0): n=17 → 0xFFFFFF85, no flags, latency 19.
- 0x4EFFFFFF: e=30, left shift 7 → 0x7FFFFF80, inexact_out=0, latency 9.
- Boundary values:
  - 0x4F000000 → 0x7FFFFFFF, overflow_out=1, latency 2.
  - 0xCF000000 → 0x80000000, no flags.
  - 0xFF800000 → 0x80000000, overflow_out=1.
  - 0x7FC00000 → 0, invalid_out=1.
- Small values:
  - 0x3F000000 (0.5) → 0, inexact_out=1.
  - 0x00000001 (denormal) → 0, inexact_out=1.
  - 0x80000000 → 0, no flags.
- Control:
  - Hold start_in high throughout a conversion: no second accept until ready_out returns.
  - Assert rst_in during SHIFT: next cycle ready_out=1, valid_out=0, integer_out=0; a subsequent 0x41200000 conversion returns 10.

Source files
------------

// File: rtl/floating_point_to_integer_if.sv
// rtl/floating_point_to_integer_if.sv - handshake and result bundle for the float-to-integer converter
//
// Purpose: groups the request/result signals of floating_point_to_integer.
// Ports (as seen by the converter, slave modport):
//   start_in      in   request, accepted only while ready_out=1
//   floating_in   in   IEEE-754 operand, sampled on the accept edge
//   ready_out     out  high only while the converter is idle
//   valid_out     out  one-cycle result pulse
//   integer_out   out  signed result, held until the next result
//   overflow_out  out  operand was out of range or +/-Inf
//   invalid_out   out  operand was NaN
//   inexact_out   out  nonzero fraction bits were discarded
interface floating_point_to_integer_if #(
  parameter int DATA_WIDTH = 32,
  parameter int INT_WIDTH  = 32
);
  logic                  start_in;
  logic [DATA_WIDTH-1:0] floating_in;
  logic                  ready_out;
  logic                  valid_out;
  logic [INT_WIDTH-1:0]  integer_out;
  logic                  overflow_out;
  logic                  invalid_out;
  logic                  inexact_out;

  modport master (
    output start_in, floating_in,
    input  ready_out, valid_out, integer_out, overflow_out, invalid_out, inexact_out
  );

  modport slave (
    input  start_in, floating_in,
    output ready_out, valid_out, integer_out, overflow_out, invalid_out, inexact_out
  );
endinterface

// File: rtl/floating_point_to_integer.sv
// rtl/floating_point_to_integer.sv - iterative IEEE-754 single to signed integer converter
//
// Purpose: unpacks a float, denormalizes the significand one bit per cycle,
// truncates toward zero and saturates out-of-range inputs.
// Ports:
//   clk_in  in  clock, all registers update on the rising edge
//   rst_in  in  synchronous active-high reset
//   bus     slave side of floating_point_to_integer_if (start/ready/valid
//           handshake, operand, result and flags)
module floating_point_to_integer #(
  parameter int DATA_WIDTH = 32,
  parameter int MENT_WIDTH = 23,
  parameter int EXPO_WIDTH = 8,
  parameter int INT_WIDTH  = 32,
  parameter int EXP_BIAS   = 127
) (
  input  logic                        clk_in,
  input  logic                        rst_in,
  floating_point_to_integer_if.slave  bus
);

  localparam int EW2   = EXPO_WIDTH + 2;
  localparam int CNT_W = $clog2(MENT_WIDTH + INT_WIDTH);

  localparam logic [EW2-1:0] BIAS_V = EW2'(EXP_BIAS);
  localparam logic [EW2-1:0] OVF_E  = EW2'(INT_WIDTH - 1);
  localparam logic [EW2-1:0] MENT_E = EW2'(MENT_WIDTH);

  localparam logic [INT_WIDTH-1:0] MIN_INT = {1'b1, {(INT_WIDTH-1){1'b0}}};
  localparam logic [INT_WIDTH-1:0] MAX_INT = {1'b0, {(INT_WIDTH-1){1'b1}}};

  typedef enum logic [2:0] {
    S_IDLE, S_CLASSIFY, S_SHIFT, S_SIGN, S_DONE
  } state_t;

  // Result category decided in CLASSIFY, consumed in SIGN.
  typedef enum logic [2:0] {
    K_NORMAL, K_NAN, K_SAT, K_MIN, K_ZERO
  } kind_t;

  state_t                  r_state, w_next;
  logic [DATA_WIDTH-1:0]   r_float;
  kind_t                   r_kind, w_kind;
  logic [INT_WIDTH-1:0]    r_sig, w_sig;
  logic [CNT_W-1:0]        r_cnt, w_cnt;
  logic                    r_left, w_left;
  logic                    r_sticky;
  logic [INT_WIDTH-1:0]    r_int, w_res_int;
  logic                    r_ovf, r_inv, r_inx;
  logic                    w_res_ovf, w_res_inv, w_res_inx;

  logic                    w_sign;
  logic [EXPO_WIDTH-1:0]   w_exp;
  logic [MENT_WIDTH-1:0]   w_mant;
  logic [EW2-1:0]          w_e;
  logic                    w_e_neg;

  assign w_sign  = r_float[DATA_WIDTH-1];
  assign w_exp   = r_float[DATA_WIDTH-2 -: EXPO_WIDTH];
  assign w_mant  = r_float[MENT_WIDTH-1:0];
  // Two guard bits keep the unbiased exponent's sign visible in the MSB.
  assign w_e     = {2'b00, w_exp} - BIAS_V;
  assign w_e_neg = w_e[EW2-1];

  // Field decode: category, shift direction and shift count.
  always_comb begin
    w_kind = K_NORMAL;
    w_left = 1'b0;
    w_cnt  = '0;
    w_sig  = {{(INT_WIDTH-MENT_WIDTH-1){1'b0}}, 1'b1, w_mant};
    if (w_exp == '1) begin
      w_kind = (w_mant != '0) ? K_NAN : K_SAT;
    end else if (w_exp == '0 || w_e_neg) begin
      w_kind = K_ZERO;
    end else if (w_e >= OVF_E) begin
      // -2^(INT_WIDTH-1) is the one value at this magnitude that fits.
      w_kind = (w_sign && w_e == OVF_E && w_mant == '0) ? K_MIN : K_SAT;
    end else if (w_e >= MENT_E) begin
      w_left = 1'b1;
      w_cnt  = CNT_W'(w_e - MENT_E);
    end else begin
      w_cnt  = CNT_W'(MENT_E - w_e);
    end
  end

  // Final value and flags for each category.
  always_comb begin
    w_res_int = '0;
    w_res_ovf = 1'b0;
    w_res_inv = 1'b0;
    w_res_inx = 1'b0;
    case (r_kind)
      K_NORMAL: begin
        w_res_int = w_sign ? (~r_sig + INT_WIDTH'(1)) : r_sig;
        w_res_inx = r_sticky;
      end
      K_NAN: w_res_inv = 1'b1;
      K_SAT: begin
        w_res_int = w_sign ? MIN_INT : MAX_INT;
        w_res_ovf = 1'b1;
      end
      K_MIN:  w_res_int = MIN_INT;
      K_ZERO: w_res_inx = |r_float[DATA_WIDTH-2:0];
      default: w_res_int = '0;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:     if (bus.start_in) w_next = S_CLASSIFY;
      S_CLASSIFY: w_next = (w_kind == K_NORMAL && w_cnt != '0) ? S_SHIFT : S_SIGN;
      S_SHIFT:    if (r_cnt == CNT_W'(1)) w_next = S_SIGN;
      S_SIGN:     w_next = S_DONE;
      S_DONE:     w_next = S_IDLE;
      default:    w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_float  <= '0;
      r_kind   <= K_NORMAL;
      r_sig    <= '0;
      r_cnt    <= '0;
      r_left   <= 1'b0;
      r_sticky <= 1'b0;
      r_int    <= '0;
      r_ovf    <= 1'b0;
      r_inv    <= 1'b0;
      r_inx    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start_in) r_float <= bus.floating_in;
        end
        S_CLASSIFY: begin
          r_kind   <= w_kind;
          r_sig    <= w_sig;
          r_cnt    <= w_cnt;
          r_left   <= w_left;
          r_sticky <= 1'b0;
        end
        S_SHIFT: begin
          if (r_left) begin
            r_sig <= r_sig << 1;
          end else begin
            r_sig    <= r_sig >> 1;
            r_sticky <= r_sticky | r_sig[0];
          end
          r_cnt <= r_cnt - CNT_W'(1);
        end
        S_SIGN: begin
          r_int <= w_res_int;
          r_ovf <= w_res_ovf;
          r_inv <= w_res_inv;
          r_inx <= w_res_inx;
        end
        default: ;
      endcase
    end
  end

  assign bus.ready_out    = (r_state == S_IDLE);
  assign bus.valid_out    = (r_state == S_DONE);
  assign bus.integer_out  = r_int;
  assign bus.overflow_out = r_ovf;
  assign bus.invalid_out  = r_inv;
  assign bus.inexact_out  = r_inx;

endmodule

// File: tb/tb_floating_point_to_integer.sv
// tb/tb_floating_point_to_integer.sv - directed vector bench for floating_point_to_integer
module tb_floating_point_to_integer;

  logic clk_in = 1'b0;
  logic rst_in;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk_in = ~clk_in;

  floating_point_to_integer_if #(.DATA_WIDTH(32), .INT_WIDTH(32)) bus ();

  floating_point_to_integer dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .bus    (bus)
  );

  typedef struct {
    logic [31:0] fin;
    logic [31:0] exp_int;
    logic [2:0]  exp_flags;  // {overflow, invalid, inexact}
    int          exp_lat;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Accepts one operand and waits for the result; lat=-1 if none arrives.
  task automatic run_conv(input logic [31:0] f, output logic [31:0] res,
                          output logic [2:0] flg, output int lat);
    int k;
    k   = 0;
    lat = -1;
    res = '0;
    flg = '0;
    while (!bus.ready_out && k < 60) begin
      @(posedge clk_in); #1;
      k++;
    end
    bus.floating_in = f;
    bus.start_in    = 1'b1;
    @(posedge clk_in); #1;
    bus.start_in    = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk_in); #1;
      if (bus.valid_out) begin
        lat = c;
        res = bus.integer_out;
        flg = {bus.overflow_out, bus.invalid_out, bus.inexact_out};
        break;
      end
    end
  endtask

  initial begin
    vec_t        vecs[$];
    logic [31:0] res;
    logic [2:0]  flg;
    int          lat;
    logic        saw_ready;
    int          c;

    vecs.push_back('{32'h40490FDB, 32'h00000003, 3'b001, 24});
    vecs.push_back('{32'hC2F60000, 32'hFFFFFF85, 3'b000, 19});
    vecs.push_back('{32'h4EFFFFFF, 32'h7FFFFF80, 3'b000,  9});
    vecs.push_back('{32'h4F000000, 32'h7FFFFFFF, 3'b100,  2});
    vecs.push_back('{32'hCF000000, 32'h80000000, 3'b000,  2});
    vecs.push_back('{32'hFF800000, 32'h80000000, 3'b100,  2});
    vecs.push_back('{32'h7F800000, 32'h7FFFFFFF, 3'b100,  2});
    vecs.push_back('{32'hCF000001, 32'h80000000, 3'b100,  2});
    vecs.push_back('{32'h7FC00000, 32'h00000000, 3'b010,  2});
    vecs.push_back('{32'h3F000000, 32'h00000000, 3'b001,  2});
    vecs.push_back('{32'h00000001, 32'h00000000, 3'b001,  2});
    vecs.push_back('{32'h80000000, 32'h00000000, 3'b000,  2});
    vecs.push_back('{32'h3F800000, 32'h00000001, 3'b000, 25});
    vecs.push_back('{32'hBFC00000, 32'hFFFFFFFF, 3'b001, 25});
    vecs.push_back('{32'h4B000000, 32'h00800000, 3'b000,  2});
    vecs.push_back('{32'h41200000, 32'h0000000A, 3'b000, 22});

    rst_in          = 1'b1;
    bus.start_in    = 1'b0;
    bus.floating_in = '0;
    repeat (3) @(posedge clk_in);
    #1;
    chk("reset_ready", 64'(bus.ready_out), 64'd1);
    chk("reset_valid", 64'(bus.valid_out), 64'd0);
    chk("reset_int", 64'(bus.integer_out), 64'd0);
    chk("reset_flags", 64'({bus.overflow_out, bus.invalid_out, bus.inexact_out}), 64'd0);
    rst_in = 1'b0;
    @(posedge clk_in); #1;

    foreach (vecs[i]) begin
      run_conv(vecs[i].fin, res, flg, lat);
      chk($sformatf("vec%0d_latency", i), 64'(lat), 64'(vecs[i].exp_lat));
      chk($sformatf("vec%0d_int", i), 64'(res), 64'(vecs[i].exp_int));
      chk($sformatf("vec%0d_flags", i), 64'(flg), 64'(vecs[i].exp_flags));
      @(posedge clk_in); #1;
      chk($sformatf("vec%0d_pulse_ready", i), 64'({bus.valid_out, bus.ready_out}), 64'b01);
      chk($sformatf("vec%0d_hold", i), 64'(bus.integer_out), 64'(vecs[i].exp_int));
    end

    // start_in held high across a whole conversion: exactly one accept.
    bus.floating_in = 32'h41200000;
    bus.start_in    = 1'b1;
    @(posedge clk_in); #1;
    saw_ready = 1'b0;
    lat       = -1;
    for (c = 1; c <= 40; c++) begin
      @(posedge clk_in); #1;
      if (bus.valid_out) begin
        lat = c;
        bus.start_in = 1'b0;
        break;
      end
      if (bus.ready_out) saw_ready = 1'b1;
    end
    bus.start_in = 1'b0;
    chk("hold_start_latency", 64'(lat), 64'd22);
    chk("hold_start_no_ready", 64'(saw_ready), 64'd0);
    chk("hold_start_int", 64'(bus.integer_out), 64'd10);
    @(posedge clk_in); #1;
    chk("hold_start_idle", 64'({bus.valid_out, bus.ready_out}), 64'b01);
    repeat (3) @(posedge clk_in);
    #1;
    chk("hold_start_no_second", 64'({bus.valid_out, bus.ready_out}), 64'b01);

    // Reset in the middle of the SHIFT phase aborts the conversion.
    bus.floating_in = 32'h40490FDB;
    bus.start_in    = 1'b1;
    @(posedge clk_in); #1;
    bus.start_in    = 1'b0;
    repeat (5) @(posedge clk_in);
    #1;
    rst_in = 1'b1;
    @(posedge clk_in); #1;
    rst_in = 1'b0;
    chk("midreset_ready", 64'(bus.ready_out), 64'd1);
    chk("midreset_valid", 64'(bus.valid_out), 64'd0);
    chk("midreset_int", 64'(bus.integer_out), 64'd0);
    run_conv(32'h41200000, res, flg, lat);
    chk("post_reset_latency", 64'(lat), 64'd22);
    chk("post_reset_int", 64'(res), 64'd10);
    chk("post_reset_flags", 64'(flg), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
